// File: rtl/vga_text_render.sv
// ============================================================================
// vga_text_render: text-mode pixel generator with blinking underline cursor.
// Rev 1.0 - initial release.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_text_render #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        blank_n,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        cur_en,
  input  logic [6:0]  cur_x,
  input  logic [4:0]  cur_y,
  output logic [11:0] char_addr,
  input  logic [15:0] char_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  pix_idx,
  output logic        h_sync_o,
  output logic        v_sync_o,
  output logic        blank_n_o
);

  localparam int          C_BW    = BLINK_LOG2 + 1;
  localparam logic [11:0] C_COLS  = 12'(COLS);
  localparam logic [7:0]  C_COLS8 = 8'(COLS);
  localparam logic [5:0]  C_ROWS6 = 6'(ROWS);

  // Control bundle carried through every stage: {blank_n, h_sync, v_sync}
  logic [2:0]      ctl0_q, ctl1_q, ctl2_q, ctl3_q, ctl_o_q;
  logic [11:0]     char_addr_q, font_addr_q;
  logic [2:0]      xsub0_q, xsub1_q, xsub2_q, xsub3_q;
  logic [3:0]      ysub0_q, ysub1_q;
  logic            cur0_q, cur1_q, cur2_q, cur3_q;
  logic [3:0]      fg2_q, bg2_q, fg3_q, bg3_q;
  logic [3:0]      pix_q, pix_d;
  logic            vs_prev_q;
  logic [C_BW-1:0] blink_q, blink_d;

  logic [6:0]      w_col;
  logic [5:0]      w_row;
  logic [11:0]     w_addr;
  logic            w_blink_vis;
  logic            w_cur_hit;
  logic            w_bit;

  assign w_col       = pos_x[9:3];
  assign w_row       = pos_y[9:4];
  assign w_addr      = {6'd0, w_row} * C_COLS + {5'd0, w_col};
  assign w_blink_vis = ~blink_q[C_BW-1];

  // Out-of-range cursor coordinates simply never match a cell
  assign w_cur_hit = cur_en & w_blink_vis
                   & ({1'b0, cur_x} < C_COLS8) & ({1'b0, cur_y} < C_ROWS6)
                   & (w_col == cur_x) & (w_row == {1'b0, cur_y})
                   & (pos_y[3:0] >= 4'd14);

  always_comb begin
    blink_d = blink_q;
    if (vs_prev_q & ~v_sync) begin
      blink_d = blink_q + C_BW'(1);
    end
  end

  always_comb begin
    w_bit = font_data[~xsub3_q] | cur3_q;
    pix_d = 4'd0;
    if (ctl3_q[2]) begin
      pix_d = w_bit ? fg3_q : bg3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl0_q      <= '0;
      ctl1_q      <= '0;
      ctl2_q      <= '0;
      ctl3_q      <= '0;
      ctl_o_q     <= '0;
      char_addr_q <= '0;
      font_addr_q <= '0;
      xsub0_q     <= '0;
      xsub1_q     <= '0;
      xsub2_q     <= '0;
      xsub3_q     <= '0;
      ysub0_q     <= '0;
      ysub1_q     <= '0;
      cur0_q      <= 1'b0;
      cur1_q      <= 1'b0;
      cur2_q      <= 1'b0;
      cur3_q      <= 1'b0;
      fg2_q       <= '0;
      bg2_q       <= '0;
      fg3_q       <= '0;
      bg3_q       <= '0;
      pix_q       <= '0;
      vs_prev_q   <= 1'b0;
      blink_q     <= '0;
    end else begin
      vs_prev_q   <= v_sync;
      blink_q     <= blink_d;
      // Stage 0: address generation and cell-local coordinates
      char_addr_q <= blank_n ? w_addr : 12'd0;
      xsub0_q     <= pos_x[2:0];
      ysub0_q     <= pos_y[3:0];
      cur0_q      <= w_cur_hit;
      ctl0_q      <= {blank_n, h_sync, v_sync};
      // Stage 1: character RAM access in flight
      xsub1_q     <= xsub0_q;
      ysub1_q     <= ysub0_q;
      cur1_q      <= cur0_q;
      ctl1_q      <= ctl0_q;
      // Stage 2: glyph address and colours from the character word
      font_addr_q <= {char_data[7:0], ysub1_q};
      fg2_q       <= char_data[11:8];
      bg2_q       <= char_data[15:12];
      xsub2_q     <= xsub1_q;
      cur2_q      <= cur1_q;
      ctl2_q      <= ctl1_q;
      // Stage 3: font ROM access in flight
      fg3_q       <= fg2_q;
      bg3_q       <= bg2_q;
      xsub3_q     <= xsub2_q;
      cur3_q      <= cur2_q;
      ctl3_q      <= ctl2_q;
      // Stage 4: pixel output
      pix_q       <= pix_d;
      ctl_o_q     <= ctl3_q;
    end
  end

  assign char_addr = char_addr_q;
  assign font_addr = font_addr_q;
  assign pix_idx   = pix_q;
  assign blank_n_o = ctl_o_q[2];
  assign h_sync_o  = ctl_o_q[1];
  assign v_sync_o  = ctl_o_q[0];

endmodule

`default_nettype wire

// File: tb/tb_vga_text_render.sv
// ============================================================================
// tb_vga_text_render: self-checking bench with RAM/ROM models and scoreboard.
// Rev 1.0 - initial release.
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_text_render;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic        blank_n = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
  logic        cur_en = 1'b0;
  logic [6:0]  cur_x = 7'd3;
  logic [4:0]  cur_y = 5'd1;
  logic [11:0] char_addr, font_addr;
  logic [15:0] char_data = '0;
  logic [7:0]  font_data = '0;
  logic [3:0]  pix_idx;
  logic        h_sync_o, v_sync_o, blank_n_o;

  logic [15:0] cram [0:4095];
  logic [7:0]  from [0:4095];

  always #5 clk = ~clk;

  vga_text_render #(.COLS(80), .ROWS(30), .BLINK_LOG2(5)) dut (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .blank_n(blank_n),
    .h_sync(h_sync), .v_sync(v_sync), .cur_en(cur_en), .cur_x(cur_x),
    .cur_y(cur_y), .char_addr(char_addr), .char_data(char_data),
    .font_addr(font_addr), .font_data(font_data), .pix_idx(pix_idx),
    .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .blank_n_o(blank_n_o)
  );

  // Synchronous character RAM and font ROM models
  always @(posedge clk) begin
    char_data <= cram[char_addr];
    font_data <= from[font_addr];
  end

  typedef struct {
    logic       chk;
    logic [3:0] pix;
    logic       hs;
    logic       vs;
    logic       bn;
  } pix_exp_t;

  typedef struct {
    logic        chk;
    logic [11:0] a;
  } addr_exp_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bn;
    logic        hs;
    logic [3:0]  pix;
    logic [11:0] ca;
    logic [11:0] fa;
  } vec_t;

  pix_exp_t  pq[$];
  addr_exp_t caq[$];
  addr_exp_t faq[$];
  vec_t      tbl [14];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one pixel clock of stimulus, queue its expectations, then retire
  // whichever queued expectations the pipeline has produced by the next negedge.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic bn,
                      input logic hs, input logic vs,
                      input logic cp, input logic [3:0] ep,
                      input logic cc, input logic [11:0] eca,
                      input logic cf, input logic [11:0] efa);
    pix_exp_t  e;
    addr_exp_t a;
    rst     = 1'b0;
    pos_x   = x;
    pos_y   = y;
    blank_n = bn;
    h_sync  = hs;
    v_sync  = vs;
    pq.push_back('{chk: cp, pix: ep, hs: hs, vs: vs, bn: bn});
    caq.push_back('{chk: cc, a: eca});
    faq.push_back('{chk: cf, a: efa});
    @(negedge clk);
    if (pq.size() == 5) begin
      e = pq.pop_front();
      if (e.chk) check("pix_idx", 32'(pix_idx), 32'(e.pix));
      check("h_sync_o", 32'(h_sync_o), 32'(e.hs));
      check("v_sync_o", 32'(v_sync_o), 32'(e.vs));
      check("blank_n_o", 32'(blank_n_o), 32'(e.bn));
    end
    if (caq.size() == 1) begin
      a = caq.pop_front();
      if (a.chk) check("char_addr", 32'(char_addr), 32'(a.a));
    end
    if (faq.size() == 3) begin
      a = faq.pop_front();
      if (a.chk) check("font_addr", 32'(font_addr), 32'(a.a));
    end
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    pos_x   = 10'($urandom);
    pos_y   = 10'($urandom);
    blank_n = 1'($urandom);
    h_sync  = 1'($urandom);
    v_sync  = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_pix_idx", 32'(pix_idx), 32'd0);
      check("rst_syncs", 32'({h_sync_o, v_sync_o, blank_n_o}), 32'd0);
      check("rst_char_addr", 32'(char_addr), 32'd0);
      check("rst_font_addr", 32'(font_addr), 32'd0);
      v_sync = ~v_sync;
    end
    pq.delete();
    caq.delete();
    faq.delete();
    // Cleared pipeline stages drain as zeros after release
    repeat (4) pq.push_back('{chk: 1'b1, pix: 4'd0, hs: 1'b0, vs: 1'b0, bn: 1'b0});
    repeat (2) faq.push_back('{chk: 1'b1, a: 12'd0});
  endtask

  initial begin
    logic [3:0] exp_pix;

    for (int i = 0; i < 4096; i++) begin
      cram[i] = 16'h0000;
      from[i] = 8'h00;
    end
    cram[0]    = 16'h3200;
    cram[1]    = 16'h1A41;
    cram[83]   = 16'h0F00;
    cram[2399] = 16'h5C07;
    from[12'h004] = 8'hFF;
    from[12'h415] = 8'b0010_0000;
    from[12'h07F] = 8'h01;

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{x: 10'(8 + i), y: 10'd5, bn: 1'b1, hs: 1'(i),
                 pix: (i == 2) ? 4'hA : 4'h1, ca: 12'd1, fa: 12'h415};
    end
    tbl[8]  = '{x: 10'd17,  y: 10'd35,  bn: 1'b1, hs: 1'b1, pix: 4'h0, ca: 12'd162,  fa: 12'h003};
    tbl[9]  = '{x: 10'd639, y: 10'd479, bn: 1'b1, hs: 1'b0, pix: 4'hC, ca: 12'd2399, fa: 12'h07F};
    tbl[10] = '{x: 10'd0,   y: 10'd4,   bn: 1'b0, hs: 1'b1, pix: 4'h0, ca: 12'd0,    fa: 12'h004};
    tbl[11] = '{x: 10'd0,   y: 10'd4,   bn: 1'b1, hs: 1'b0, pix: 4'h2, ca: 12'd0,    fa: 12'h004};
    tbl[12] = '{x: 10'd5,   y: 10'd4,   bn: 1'b0, hs: 1'b1, pix: 4'h0, ca: 12'd0,    fa: 12'h004};
    tbl[13] = '{x: 10'd638, y: 10'd479, bn: 1'b1, hs: 1'b0, pix: 4'h5, ca: 12'd2399, fa: 12'h07F};

    do_reset(3);

    // Blanked lines after release: pixel stays 0, syncs track 4 clocks later
    for (int i = 0; i < 6; i++) begin
      step(10'd0, 10'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b1,
           1'b1, 4'd0, 1'b1, 12'd0, 1'b0, 12'd0);
    end

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].x, tbl[i].y, tbl[i].bn, tbl[i].hs, 1'b1,
           1'b1, tbl[i].pix, 1'b1, tbl[i].ca, 1'b1, tbl[i].fa);
    end

    // Cursor blink across 100 frames, each ending in a v_sync falling edge
    cur_en = 1'b1;
    for (int f = 0; f < 100; f++) begin
      exp_pix = ((f % 64) < 32) ? 4'hF : 4'h0;
      step(10'd25, 10'd30, 1'b1, 1'b0, 1'b1, 1'b1, exp_pix, 1'b1, 12'd83, 1'b1, 12'h00E);
      step(10'd0,  10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 4'd0,    1'b1, 12'd0,  1'b1, 12'h000);
      step(10'd0,  10'd0,  1'b0, 1'b1, 1'b0, 1'b1, 4'd0,    1'b1, 12'd0,  1'b1, 12'h000);
      step(10'd0,  10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 4'd0,    1'b1, 12'd0,  1'b1, 12'h000);
    end

    // Counter now 36: cursor hidden; reset with pixels in flight restores it
    step(10'd25, 10'd30, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 12'd83, 1'b1, 12'h00E);
    step(10'd0,  10'd4,  1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 12'd0,  1'b1, 12'h004);
    do_reset(2);
    step(10'd25, 10'd30, 1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 12'd83, 1'b1, 12'h00E);
    step(10'd25, 10'd29, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 12'd83, 1'b1, 12'h00D);
    cur_en = 1'b0;
    step(10'd25, 10'd30, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 12'd83, 1'b1, 12'h00E);
    cur_en = 1'b1;
    cur_x  = 7'd80;
    step(10'd639, 10'd30, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, 12'd159, 1'b1, 12'h00E);
    cur_x  = 7'd3;
    for (int i = 0; i < 5; i++) begin
      step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 12'd0, 1'b1, 12'h000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Text-mode pixel generator sitting directly downstream of the VGA timing generator.
- Consumes pos_x/pos_y/blank_n/h_sync/v_sync and addresses an external character RAM and font ROM, both synchronous.
- Emits a 4-bit colour index per pixel, with sync and blank delayed to match the pipeline.
- Draws a blinking underline cursor at a programmable cell.

Parameters:
- COLS, 80, characters per row (cell width fixed at 8 px).
- ROWS, 30, character rows (cell height fixed at 16 px).
- BLINK_LOG2, 5, cursor toggles every 2^BLINK_LOG2 frames.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- pos_x  in  10  pixel column, valid when blank_n=1
- pos_y  in  10  pixel row, valid when blank_n=1
- blank_n  in  1  1 = active video
- h_sync  in  1  horizontal sync, passed through (polarity preserved)
- v_sync  in  1  vertical sync, passed through (polarity preserved)
- cur_en  in  1  cursor enable, quasi-static
- cur_x  in  7  cursor column 0..COLS-1
- cur_y  in  5  cursor row 0..ROWS-1
- char_addr  out  12  character RAM address, registered
- char_data  in  16  RAM data, valid 1 clk after char_addr; [7:0] code, [11:8] fg, [15:12] bg
- font_addr  out  12  font ROM address = {code, glyph_row}, registered
- font_data  in  8  ROM data, valid 1 clk after font_addr; bit7 = leftmost pixel
- pix_idx  out  4  colour index, registered
- h_sync_o  out  1  h_sync delayed by LATENCY
- v_sync_o  out  1  v_sync delayed by LATENCY
- blank_n_o  out  1  blank_n delayed by LATENCY

Behaviour:
- Clock and reset: clk, rst — reset is synchronous, active-high. All registers clear to 0, including char_addr, font_addr, pix_idx, h_sync_o, v_sync_o, blank_n_o, blink counter and all pipeline stages.
- LATENCY = 4. Inputs sampled at edge N appear on pix_idx/h_sync_o/v_sync_o/blank_n_o after edge N+4. Syncs and blank always pass through this fixed pipeline, including during blanking.
- Stage timing:
  - Edge N: char_addr <= blank_n ? (pos_y>>4)*COLS + (pos_x>>3) : 0. Also capture x_sub=pos_x[2:0], y_sub=pos_y[3:0], cursor-hit.
  - Edge N+1: RAM captures char_addr; char_data is valid after this edge.
  - Edge N+2: font_addr <= {char_data[7:0], y_sub}; fg/bg are captured.
  - Edge N+3: ROM captures font_addr; font_data is valid after this edge.
  - Edge N+4: pixel output (see next bullet). fg, bg, x_sub, cursor flag and blank are delayed so they align with font_data.
- Pixel output at edge N+4:
  - pix_idx = 0 if delayed blank_n = 0.
  - Otherwise bit = font_data[7 - x_sub]; if cursor_on, bit is forced to 1.
  - pix_idx = bit ? fg : bg.
- cursor_on = cur_en & (pos_x>>3 == cur_x) & (pos_y>>4 == cur_y) & (y_sub >= 14) & blink_vis. Evaluated at edge N and pipelined.
- Address arithmetic: row*COLS is computed in ≥12 bits, result truncated to 12. Max address with defaults is 2399.
- Blink counter (BLINK_LOG2+1 bits):
  - Increments by 1 on each detected v_sync 1→0 transition, using v_sync registered one clock for the comparison.
  - Wraps modulo 2^(BLINK_LOG2+1).
  - blink_vis = ~counter MSB, so the cursor is visible for the first 32 frames after reset.
- A v_sync edge coinciding with rst: reset wins and the counter stays 0.
- Reset mid-line: outputs go to 0 on the next edge. Pipeline contents are discarded; valid output resumes 4 clocks after rst deasserts.
- Cursor coordinates out of range (cur_x ≥ COLS or cur_y ≥ ROWS): no cell matches, no cursor drawn, no error.
- Inputs outside the text area while blank_n=1 (pos beyond COLS*8 or ROWS*16) are not clamped. This cannot occur with the default 640x480 timing.

Test Plan:
- Reset: hold rst 3 clks with random inputs → all outputs 0 and char_addr=0. After release with blank_n=0 → pix_idx stays 0 and h_sync_o tracks h_sync exactly 4 clks later.
- Address map: pos_x=17, pos_y=35, blank_n=1 → char_addr=162 (row 2 × 80 + col 2) one edge later. pos_x=639, pos_y=479 → 2399.
- Glyph pixel: char_data=16'h1A41, y_sub=5, font model returns 8'b0010_0000, x sweeps 0..7 in the cell:
  - font_addr=12'h415.
  - pix_idx=A only at x_sub=2, 1 elsewhere.
  - Output appears 4 clks after each input.
- Blanking: blank_n=0 with font_data=8'hFF → pix_idx=0. blank_n_o rises exactly 4 clks after blank_n rises.
- Cursor blink: cur_en=1, cur_x=3, cur_y=1, pixel (25,30), fg=F, bg=0, glyph all-zero:
  - Frames 0–31: pix_idx=F.
  - Frames 32–63: pix_idx=0.
  - Frame 64 onward: pix_idx=F again, after 64 v_sync falling edges (counter wrap).
- Reset mid-frame: assert rst with a non-zero blink count and in-flight pixels → next-edge outputs 0, counter 0, cursor visible on the first frame after release.
